// File: rtl/sync_edge_timestamper.sv
// Synchronises and glitch-filters LSYNC/RSYNC, timestamps accepted edges against a
// free-running timebase, and reports SYNC falls with a direction flag and order check.
module sync_edge_timestamper #(
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             lsync_in,
    input  logic             rsync_in,
    output logic [CNT_W-1:0] timebase,
    output logic [CNT_W-1:0] lsync_rise_time,
    output logic [CNT_W-1:0] lsync_fall_time,
    output logic [CNT_W-1:0] rsync_rise_time,
    output logic [CNT_W-1:0] rsync_fall_time,
    output logic             scan_dir,
    output logic             sync_pulse,
    output logic             seq_error,
    output logic [7:0]       seq_err_count
);

    localparam logic [1:0]       ST_IDLE   = 2'd0;
    localparam logic [1:0]       ST_EXP_R  = 2'd1;
    localparam logic [1:0]       ST_EXP_L  = 2'd2;
    localparam logic [3:0]       FILT_LAST = 4'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] TB_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sync1_l_r, s_l_r, sync1_r_r, s_r_r;
    logic             filt_l_r, filt_r_r;
    logic [3:0]       cnt_l_r, cnt_r_r;
    logic [CNT_W-1:0] cand_l_r, cand_r_r;
    logic [1:0]       state_r;
    logic             pend_r, pend_side_r;

    logic             mis_l_s, acc_l_s, mis_r_s, acc_r_s;
    logic [CNT_W-1:0] cand_nxt_l_s, cand_nxt_r_s;
    logic             rise_l_s, fall_l_s, rise_r_s, fall_r_s;
    logic             rep_vld_s, rep_side_s, rep_err_s;
    logic             pend_set_s, pend_side_nxt_s;
    logic [1:0]       state_nxt_s;

    // Free-running timebase, paused while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timebase <= '0;
        end else if (enable) begin
            timebase <= timebase + TB_ONE;
        end
    end

    // Two-flop synchronisers for both raw inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_l_r <= 1'b0;
            s_l_r     <= 1'b0;
            sync1_r_r <= 1'b0;
            s_r_r     <= 1'b0;
        end else begin
            sync1_l_r <= lsync_in;
            s_l_r     <= sync1_l_r;
            sync1_r_r <= rsync_in;
            s_r_r     <= sync1_r_r;
        end
    end

    // Filter decode; the candidate bypass lets a one-sample filter report its own edge.
    always_comb begin
        mis_l_s      = (s_l_r != filt_l_r);
        acc_l_s      = mis_l_s && (cnt_l_r == FILT_LAST);
        mis_r_s      = (s_r_r != filt_r_r);
        acc_r_s      = mis_r_s && (cnt_r_r == FILT_LAST);
        if (cnt_l_r == 4'd0) begin
            cand_nxt_l_s = timebase;
        end else begin
            cand_nxt_l_s = cand_l_r;
        end
        if (cnt_r_r == 4'd0) begin
            cand_nxt_r_s = timebase;
        end else begin
            cand_nxt_r_s = cand_r_r;
        end
        rise_l_s = acc_l_s && !filt_l_r && enable;
        fall_l_s = acc_l_s &&  filt_l_r && enable;
        rise_r_s = acc_r_s && !filt_r_r && enable;
        fall_r_s = acc_r_s &&  filt_r_r && enable;
    end

    // Glitch filters: level changes only after FILT_LEN consecutive mismatching samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_l_r <= 1'b0;
            filt_r_r <= 1'b0;
            cnt_l_r  <= 4'd0;
            cnt_r_r  <= 4'd0;
            cand_l_r <= '0;
            cand_r_r <= '0;
        end else begin
            if (!mis_l_s || acc_l_s) begin
                cnt_l_r <= 4'd0;
            end else begin
                cnt_l_r <= cnt_l_r + 4'd1;
            end
            if (!mis_r_s || acc_r_s) begin
                cnt_r_r <= 4'd0;
            end else begin
                cnt_r_r <= cnt_r_r + 4'd1;
            end
            if (acc_l_s) begin
                filt_l_r <= ~filt_l_r;
            end
            if (acc_r_s) begin
                filt_r_r <= ~filt_r_r;
            end
            if (mis_l_s && (cnt_l_r == 4'd0)) begin
                cand_l_r <= timebase;
            end
            if (mis_r_s && (cnt_r_r == 4'd0)) begin
                cand_r_r <= timebase;
            end
        end
    end

    // Timestamp capture on accepted edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lsync_rise_time <= '0;
            lsync_fall_time <= '0;
            rsync_rise_time <= '0;
            rsync_fall_time <= '0;
        end else begin
            if (rise_l_s) begin
                lsync_rise_time <= cand_nxt_l_s;
            end
            if (fall_l_s) begin
                lsync_fall_time <= cand_nxt_l_s;
            end
            if (rise_r_s) begin
                rsync_rise_time <= cand_nxt_r_s;
            end
            if (fall_r_s) begin
                rsync_fall_time <= cand_nxt_r_s;
            end
        end
    end

    // Choose which fall to report; on a tie the side the FSM expects goes first.
    always_comb begin
        rep_vld_s       = 1'b0;
        rep_side_s      = 1'b0;
        pend_set_s      = 1'b0;
        pend_side_nxt_s = 1'b0;
        if (fall_l_s && fall_r_s) begin
            rep_vld_s  = 1'b1;
            pend_set_s = 1'b1;
            case (state_r)
                ST_EXP_L: rep_side_s = 1'b1;
                default:  rep_side_s = 1'b0;
            endcase
            pend_side_nxt_s = ~rep_side_s;
        end else if (fall_l_s) begin
            rep_vld_s  = 1'b1;
            rep_side_s = 1'b1;
        end else if (fall_r_s) begin
            rep_vld_s  = 1'b1;
            rep_side_s = 1'b0;
        end else if (pend_r) begin
            rep_vld_s  = 1'b1;
            rep_side_s = pend_side_r;
        end else begin
            rep_vld_s  = 1'b0;
        end
        // A fall always leads to "expect the other side"; staying put means a repeat.
        state_nxt_s = rep_side_s ? ST_EXP_R : ST_EXP_L;
        rep_err_s   = rep_vld_s && (state_r == state_nxt_s);
    end

    // Fall reporting, alternation FSM and saturating error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            pend_r        <= 1'b0;
            pend_side_r   <= 1'b0;
            scan_dir      <= 1'b0;
            sync_pulse    <= 1'b0;
            seq_error     <= 1'b0;
            seq_err_count <= 8'd0;
        end else begin
            sync_pulse  <= rep_vld_s;
            seq_error   <= rep_err_s;
            pend_r      <= pend_set_s;
            pend_side_r <= pend_side_nxt_s;
            if (rep_vld_s) begin
                scan_dir <= rep_side_s;
                state_r  <= state_nxt_s;
            end
            if (rep_err_s && (seq_err_count != 8'hFF)) begin
                seq_err_count <= seq_err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sync_edge_timestamper.sv
// Directed bench for sync_edge_timestamper: expected fall reports are queued when the
// raw inputs are driven and compared when sync_pulse appears.
module tb_sync_edge_timestamper;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        lsync_in;
    logic        rsync_in;
    logic        w_lsync;
    logic        w_rsync;
    logic [31:0] timebase, lsync_rise_time, lsync_fall_time, rsync_rise_time, rsync_fall_time;
    logic        scan_dir, sync_pulse, seq_error;
    logic [7:0]  seq_err_count;
    logic [7:0]  w_timebase, w_lrt, w_lft, w_rrt, w_rft, w_cnt;
    logic        w_dir, w_pulse, w_err;

    typedef struct packed {
        logic        side;
        logic        err;
        logic [31:0] ts;
    } ev_t;

    ev_t         sb_q[$];
    int          n_assert;
    int          n_fail;
    logic [31:0] exp_tb;
    logic        have_last;
    logic        last_side;
    int          exp_errs;
    logic [31:0] l_rise_exp, l_fall_exp, r_rise_exp;

    sync_edge_timestamper #(.CNT_W(32), .FILT_LEN(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .lsync_in(lsync_in), .rsync_in(rsync_in),
        .timebase(timebase),
        .lsync_rise_time(lsync_rise_time), .lsync_fall_time(lsync_fall_time),
        .rsync_rise_time(rsync_rise_time), .rsync_fall_time(rsync_fall_time),
        .scan_dir(scan_dir), .sync_pulse(sync_pulse), .seq_error(seq_error),
        .seq_err_count(seq_err_count)
    );

    sync_edge_timestamper #(.CNT_W(8), .FILT_LEN(4)) u_wrap (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .lsync_in(w_lsync), .rsync_in(w_rsync),
        .timebase(w_timebase),
        .lsync_rise_time(w_lrt), .lsync_fall_time(w_lft),
        .rsync_rise_time(w_rrt), .rsync_fall_time(w_rft),
        .scan_dir(w_dir), .sync_pulse(w_pulse), .seq_error(w_err),
        .seq_err_count(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (enable) exp_tb = exp_tb + 32'd1;
        @(negedge clk);
    endtask

    task automatic push_ev(input logic side, input logic [31:0] ts);
        ev_t e;
        e.side = side;
        e.ts   = ts;
        e.err  = have_last && (last_side == side);
        if (e.err) exp_errs++;
        have_last = 1'b1;
        last_side = side;
        sb_q.push_back(e);
    endtask

    task automatic wait_pulse(input int exp_lat);
        int lat;
        lat = 0;
        while (!sync_pulse && lat < 40) begin
            tick();
            lat++;
        end
        chk("pulse_latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_pop();
        ev_t e;
        n_assert++;
        assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_pop: observed empty queue expected entry");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sync_pulse", 64'(sync_pulse), 64'd1);
            chk("scan_dir", 64'(scan_dir), 64'(e.side));
            chk("seq_error", 64'(seq_error), 64'(e.err));
            chk("fall_time", 64'(e.side ? lsync_fall_time : rsync_fall_time), 64'(e.ts));
        end
    endtask

    task automatic rise(input logic do_l, input logic do_r);
        logic [31:0] ts;
        ts = exp_tb + 32'd2;
        if (do_l) lsync_in = 1'b1;
        if (do_r) rsync_in = 1'b1;
        repeat (5) tick();
        if (do_l) chk("lsync_rise_early", 64'(lsync_rise_time), 64'(l_rise_exp));
        tick();
        if (do_l) begin
            chk("lsync_rise_time", 64'(lsync_rise_time), 64'(ts));
            l_rise_exp = ts;
        end
        if (do_r) begin
            chk("rsync_rise_time", 64'(rsync_rise_time), 64'(ts));
            r_rise_exp = ts;
        end
        chk("no_pulse_on_rise", 64'(sync_pulse), 64'd0);
        repeat (4) tick();
    endtask

    task automatic fall(input logic do_l, input logic do_r);
        logic [31:0] ts;
        logic        first;
        ts = exp_tb + 32'd2;
        if (do_l && do_r) begin
            first = have_last && !last_side;
            push_ev(first, ts);
            push_ev(~first, ts);
        end else begin
            push_ev(do_l, ts);
        end
        if (do_l) begin
            lsync_in   = 1'b0;
            l_fall_exp = ts;
        end
        if (do_r) rsync_in = 1'b0;
        wait_pulse(6);
        check_pop();
        tick();
        if (do_l && do_r) begin
            chk("both_fall_l", 64'(lsync_fall_time), 64'(ts));
            check_pop();
            tick();
        end
        chk("pulse_single", 64'(sync_pulse), 64'd0);
        chk("seq_error_single", 64'(seq_error), 64'd0);
        chk("seq_err_count", 64'(seq_err_count), 64'(exp_errs));
    endtask

    initial begin
        logic [31:0] ts;
        int          guard;
        n_assert   = 0;
        n_fail     = 0;
        exp_tb     = 32'd0;
        have_last  = 1'b0;
        last_side  = 1'b0;
        exp_errs   = 0;
        l_rise_exp = 32'd0;
        l_fall_exp = 32'd0;
        r_rise_exp = 32'd0;
        reset_n    = 1'b0;
        enable     = 1'b0;
        lsync_in   = 1'b0;
        rsync_in   = 1'b0;
        w_lsync    = 1'b0;
        w_rsync    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_timebase", 64'(timebase), 64'd0);
        chk("rst_lrise", 64'(lsync_rise_time), 64'd0);
        chk("rst_pulse", 64'(sync_pulse), 64'd0);
        chk("rst_dir", 64'(scan_dir), 64'd0);
        chk("rst_errcnt", 64'(seq_err_count), 64'd0);

        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (10) tick();
        chk("timebase_run", 64'(timebase), 64'(exp_tb));

        // rise timestamps with filter latency
        rise(1'b1, 1'b0);
        rise(1'b0, 1'b1);

        // L fall then R fall: alternating, no sequence error
        fall(1'b1, 1'b0);
        repeat (43) tick();
        fall(1'b0, 1'b1);

        // 3-cycle glitch rejected, 4-cycle pulse accepted (its fall repeats R)
        rsync_in = 1'b1;
        repeat (3) tick();
        rsync_in = 1'b0;
        repeat (12) tick();
        chk("glitch_rise_unchanged", 64'(rsync_rise_time), 64'(r_rise_exp));
        ts = exp_tb + 32'd2;
        rsync_in = 1'b1;
        repeat (4) tick();
        rsync_in = 1'b0;
        repeat (2) tick();
        chk("pulse4_rise", 64'(rsync_rise_time), 64'(ts));
        r_rise_exp = ts;
        push_ev(1'b0, ts + 32'd4);
        wait_pulse(4);
        check_pop();
        tick();
        chk("glitch_errcnt", 64'(seq_err_count), 64'(exp_errs));

        // two consecutive L falls
        rise(1'b1, 1'b0);
        fall(1'b1, 1'b0);
        rise(1'b1, 1'b0);
        fall(1'b1, 1'b0);

        // simultaneous falls in EXP_L, then confirm state with an L fall
        rise(1'b0, 1'b1);
        fall(1'b0, 1'b1);
        rise(1'b1, 1'b1);
        fall(1'b1, 1'b1);
        rise(1'b1, 1'b0);
        fall(1'b1, 1'b0);

        // disabled: timebase holds, edges filtered but not reported
        enable = 1'b0;
        repeat (5) tick();
        chk("tb_hold", 64'(timebase), 64'(exp_tb));
        lsync_in = 1'b1;
        repeat (10) tick();
        chk("dis_rise", 64'(lsync_rise_time), 64'(l_rise_exp));
        lsync_in = 1'b0;
        repeat (10) tick();
        chk("dis_fall", 64'(lsync_fall_time), 64'(l_fall_exp));
        chk("dis_pulse", 64'(sync_pulse), 64'd0);
        enable = 1'b1;

        // 8-bit instance wraps cleanly
        guard = 0;
        while (exp_tb[7:0] != 8'd252 && guard < 400) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 6; i++) begin
            chk("wrap_tb", 64'(w_timebase), 64'(exp_tb[7:0]));
            tick();
        end
        chk("main_tb", 64'(timebase), 64'(exp_tb));

        // async reset mid-filter
        lsync_in = 1'b1;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_timebase", 64'(timebase), 64'd0);
        chk("arst_lrise", 64'(lsync_rise_time), 64'd0);
        chk("arst_lfall", 64'(lsync_fall_time), 64'd0);
        chk("arst_rrise", 64'(rsync_rise_time), 64'd0);
        chk("arst_rfall", 64'(rsync_fall_time), 64'd0);
        chk("arst_dir", 64'(scan_dir), 64'd0);
        chk("arst_errcnt", 64'(seq_err_count), 64'd0);
        chk("arst_wrap", 64'(w_timebase), 64'd0);
        lsync_in = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        exp_tb    = 32'd0;
        have_last = 1'b0;
        exp_errs  = 0;
        repeat (12) tick();
        chk("post_rst_rise", 64'(lsync_rise_time), 64'd0);
        chk("post_rst_pulse", 64'(sync_pulse), 64'd0);
        chk("post_rst_tb", 64'(timebase), 64'(exp_tb));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
